// File: rtl/reg_rd_pkg.sv
// Shared types and sizing helpers for the wide-register read path.
// Provides the reader FSM state, default widths and beat-count helpers.
package reg_rd_pkg;

    localparam int REG_WIDTH = 128;
    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    function automatic int beat_count(int dw, int bw);
        return dw / bw;
    endfunction

    // Never narrower than one bit so a single-beat build still has a port.
    function automatic int index_width(int dw, int bw);
        int n;
        n = dw / bw;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beat_select.sv
// Combinational slice mux: picks one BEAT_WIDTH slice of a wide word.
// Ports: shadow (wide word), index (emission-order beat), beat (slice).
module beat_select
    import reg_rd_pkg::*;
#(
    parameter int DATA_WIDTH = REG_WIDTH,
    parameter int BEAT_WIDTH = BUS_WIDTH,
    parameter bit MSW_FIRST  = 1'b0,
    localparam int N  = beat_count(DATA_WIDTH, BEAT_WIDTH),
    localparam int IW = index_width(DATA_WIDTH, BEAT_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] shadow,
    input  logic [IW-1:0]         index,
    output logic [BEAT_WIDTH-1:0] beat
);

    int slot;

    // Emission order maps to slice position; MSW-first walks downward.
    always_comb begin
        slot = MSW_FIRST ? (N - 1 - int'(index)) : int'(index);
        beat = shadow[slot*BEAT_WIDTH +: BEAT_WIDTH];
    end

endmodule

// File: rtl/register_128_reader.sv
// Captures a wide register on Start and streams it as narrow beats.
// Ports: Clock/Clear, Q/Start in, Beat/Valid/Ready/Index/Last, Busy/Done.
module register_128_reader
    import reg_rd_pkg::*;
#(
    parameter int DATA_WIDTH = REG_WIDTH,
    parameter int BEAT_WIDTH = BUS_WIDTH,
    parameter bit MSW_FIRST  = 1'b0,
    localparam int N  = beat_count(DATA_WIDTH, BEAT_WIDTH),
    localparam int IW = index_width(DATA_WIDTH, BEAT_WIDTH)
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [DATA_WIDTH-1:0] Q,
    input  logic                  Start,
    output logic                  Busy,
    output logic [BEAT_WIDTH-1:0] Beat,
    output logic                  Valid,
    input  logic                  Ready,
    output logic [IW-1:0]         Index,
    output logic                  Last,
    output logic                  Done
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shadow;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state  <= IDLE;
            shadow <= '0;
            Index  <= '0;
            Busy   <= 1'b0;
            Valid  <= 1'b0;
            Last   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        shadow <= Q;
                        Index  <= '0;
                        state  <= SEND;
                        Busy   <= 1'b1;
                        Valid  <= 1'b1;
                        Last   <= (N == 1);
                    end
                end
                SEND: begin
                    // Without Ready everything holds, so Beat stays put.
                    if (Ready) begin
                        if (Index == LAST_IDX) begin
                            state <= DONE;
                            Valid <= 1'b0;
                            Last  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            Index <= Index + IW'(1);
                            Last  <= ((Index + IW'(1)) == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    Index <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat depends only on registered shadow and Index.
    beat_select #(
        .DATA_WIDTH(DATA_WIDTH),
        .BEAT_WIDTH(BEAT_WIDTH),
        .MSW_FIRST (MSW_FIRST)
    ) u_sel (
        .shadow(shadow),
        .index (Index),
        .beat  (Beat)
    );

endmodule

// File: tb/tb_register_128_reader.sv
// Directed bench for register_128_reader (LSW-first and MSW-first builds).
// Ports: drives Clock/Clear/Q/Start/Ready, checks all outputs.
module tb_register_128_reader;

    logic         Clock;
    logic         Clear;
    logic [127:0] Q;
    logic         Start;
    logic         Ready;

    logic         Busy0, Valid0, Last0, Done0;
    logic [31:0]  Beat0;
    logic [1:0]   Index0;
    logic         Busy1, Valid1, Last1, Done1;
    logic [31:0]  Beat1;
    logic [1:0]   Index1;

    int errors = 0;
    int checks = 0;

    register_128_reader #(.MSW_FIRST(1'b0)) dut0 (
        .Clock(Clock), .Clear(Clear), .Q(Q), .Start(Start),
        .Busy(Busy0), .Beat(Beat0), .Valid(Valid0), .Ready(Ready),
        .Index(Index0), .Last(Last0), .Done(Done0)
    );

    register_128_reader #(.MSW_FIRST(1'b1)) dut1 (
        .Clock(Clock), .Clear(Clear), .Q(Q), .Start(Start),
        .Busy(Busy1), .Beat(Beat1), .Valid(Valid1), .Ready(Ready),
        .Index(Index1), .Last(Last1), .Done(Done1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic         clr;
        logic         st;
        logic         rdy;
        logic [127:0] q;
        logic         v;
        logic [31:0]  beat;
        logic [1:0]   idx;
        logic         l;
        logic         d;
        logic         b;
        logic         cb;
    } vec_t;

    localparam int NV = 26;
    vec_t tv [NV];

    function automatic vec_t mk(logic clr, logic st, logic rdy,
                                logic [127:0] q, logic v,
                                logic [31:0] beat, logic [1:0] idx,
                                logic l, logic d, logic b, logic cb);
        vec_t r;
        r.clr = clr; r.st = st; r.rdy = rdy; r.q = q;
        r.v = v; r.beat = beat; r.idx = idx;
        r.l = l; r.d = d; r.b = b; r.cb = cb;
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [127:0] qa, q6, qf, qm, qc, qe;
    logic [31:0]  msw_exp [4];

    initial begin
        qa = 128'h0006_0000_0003;
        q6 = 128'h0000_0006;
        qf = '1;
        qm = 128'h11111111_22222222_33333333_44444444;
        qc = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        qe = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
        msw_exp[0] = 32'h11111111;
        msw_exp[1] = 32'h22222222;
        msw_exp[2] = 32'h33333333;
        msw_exp[3] = 32'h44444444;

        // clr st rdy q | v beat idx l d b cb
        tv[0]  = mk(1, 1, 0, qf, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 0, 1, qf, 0, 0, 0, 0, 0, 0, 1);
        tv[2]  = mk(0, 1, 1, qa, 0, 0, 0, 0, 0, 0, 1);
        tv[3]  = mk(0, 0, 1, qa, 1, 32'h3, 0, 0, 0, 1, 1);
        tv[4]  = mk(0, 0, 1, qa, 1, 32'h6, 1, 0, 0, 1, 1);
        tv[5]  = mk(0, 0, 1, qa, 1, 32'h0, 2, 0, 0, 1, 1);
        tv[6]  = mk(0, 0, 1, qa, 1, 32'h0, 3, 1, 0, 1, 1);
        tv[7]  = mk(0, 0, 1, qa, 0, 0, 0, 0, 1, 1, 0);
        tv[8]  = mk(0, 0, 1, qa, 0, 0, 0, 0, 0, 0, 0);
        tv[9]  = mk(0, 1, 0, qa, 0, 0, 0, 0, 0, 0, 0);
        tv[10] = mk(0, 0, 1, qa, 1, 32'h3, 0, 0, 0, 1, 1);
        tv[11] = mk(0, 0, 0, qa, 1, 32'h6, 1, 0, 0, 1, 1);
        tv[12] = mk(0, 0, 0, qa, 1, 32'h6, 1, 0, 0, 1, 1);
        tv[13] = mk(0, 0, 1, qa, 1, 32'h6, 1, 0, 0, 1, 1);
        tv[14] = mk(0, 0, 1, qa, 1, 32'h0, 2, 0, 0, 1, 1);
        tv[15] = mk(0, 0, 0, qa, 1, 32'h0, 3, 1, 0, 1, 1);
        tv[16] = mk(0, 0, 1, qa, 1, 32'h0, 3, 1, 0, 1, 1);
        tv[17] = mk(0, 0, 0, qa, 0, 0, 0, 0, 1, 1, 0);
        tv[18] = mk(0, 0, 0, qa, 0, 0, 0, 0, 0, 0, 0);
        tv[19] = mk(0, 1, 1, q6, 0, 0, 0, 0, 0, 0, 0);
        tv[20] = mk(0, 0, 1, qf, 1, 32'h6, 0, 0, 0, 1, 1);
        tv[21] = mk(0, 1, 1, qf, 1, 32'h0, 1, 0, 0, 1, 1);
        tv[22] = mk(0, 1, 1, qf, 1, 32'h0, 2, 0, 0, 1, 1);
        tv[23] = mk(0, 0, 1, qf, 1, 32'h0, 3, 1, 0, 1, 1);
        tv[24] = mk(0, 1, 1, qf, 0, 0, 0, 0, 1, 1, 0);
        tv[25] = mk(0, 0, 1, qf, 0, 0, 0, 0, 0, 0, 0);

        Clear = 1'b1;
        Start = 1'b0;
        Ready = 1'b0;
        Q     = '0;

        for (int i = 0; i < NV; i++) begin
            @(negedge Clock);
            Clear = tv[i].clr;
            Start = tv[i].st;
            Ready = tv[i].rdy;
            Q     = tv[i].q;
            if (i != 0) begin
                chk($sformatf("row%0d valid", i), 128'(Valid0), 128'(tv[i].v));
                chk($sformatf("row%0d busy", i), 128'(Busy0), 128'(tv[i].b));
                chk($sformatf("row%0d done", i), 128'(Done0), 128'(tv[i].d));
                chk($sformatf("row%0d last", i), 128'(Last0), 128'(tv[i].l));
                if (tv[i].cb) begin
                    chk($sformatf("row%0d beat", i), 128'(Beat0), 128'(tv[i].beat));
                    chk($sformatf("row%0d index", i), 128'(Index0), 128'(tv[i].idx));
                end
            end
        end

        // MSW-first ordering on the second instance.
        @(negedge Clock);
        Q = qm; Start = 1'b1; Ready = 1'b1;
        chk("msw idle busy", 128'(Busy1), 128'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            Start = 1'b0;
            chk($sformatf("msw beat%0d", k), 128'(Beat1), 128'(msw_exp[k]));
            chk($sformatf("msw index%0d", k), 128'(Index1), 128'(k));
            chk($sformatf("msw valid%0d", k), 128'(Valid1), 128'(1));
            chk($sformatf("msw last%0d", k), 128'(Last1), 128'(k == 3));
        end
        @(negedge Clock);
        chk("msw done", 128'(Done1), 128'(1));
        @(negedge Clock);
        chk("msw back idle", 128'(Busy1), 128'(0));
        chk("msw done gone", 128'(Done1), 128'(0));

        // Clear mid-transfer, then a fresh read starts from beat 0.
        @(negedge Clock);
        Q = qc; Start = 1'b1; Ready = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        chk("clr beat0", 128'(Beat0), 128'(32'hAAAAAAAA));
        @(negedge Clock);
        chk("clr beat1", 128'(Beat0), 128'(32'hBBBBBBBB));
        @(negedge Clock);
        chk("clr beat2 valid", 128'(Valid0), 128'(1));
        chk("clr beat2 index", 128'(Index0), 128'(2));
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        chk("clr valid", 128'(Valid0), 128'(0));
        chk("clr busy", 128'(Busy0), 128'(0));
        chk("clr done", 128'(Done0), 128'(0));
        chk("clr index", 128'(Index0), 128'(0));
        chk("clr beat", 128'(Beat0), 128'(0));
        @(negedge Clock);
        chk("clr no done", 128'(Done0), 128'(0));
        chk("clr still idle", 128'(Busy0), 128'(0));
        Q = qe; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        chk("fresh beat0", 128'(Beat0), 128'(32'h3C3C3C3C));
        chk("fresh index0", 128'(Index0), 128'(0));
        chk("fresh valid", 128'(Valid0), 128'(1));
        @(negedge Clock);
        chk("fresh beat1", 128'(Beat0), 128'(32'h2D2D2D2D));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
